hwlp_ctrl: RTL

// Hardware-loop controller for the MAGE access path. Sequences an N_LP-deep loop nest
// and produces one IV tuple per cycle, plus per-loop last-iteration flags and an end

---
 rtl/hwlp_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/hwlp_ctrl.sv
// hwlp_ctrl: hardware-loop nest sequencer producing one IV tuple per cycle,
// with last/end flags and an RF enable that stays high through a drain window.
module hwlp_ctrl #(
    parameter int N_LP         = 2,
    parameter int NBIT_LP_IV   = 8,
    parameter int HWLP_RF_SIZE = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         start_i,
    input  logic                         clear_i,
    input  logic                         stall_i,
    input  logic [N_LP*NBIT_LP_IV-1:0]   lp_init_i,
    input  logic [N_LP*NBIT_LP_IV-1:0]   lp_bound_i,
    input  logic [N_LP*NBIT_LP_IV-1:0]   lp_stride_i,
    output logic                         rf_en_o,
    output logic                         hwlp_valid_o,
    output logic [N_LP*NBIT_LP_IV-1:0]   loop_vars_o,
    output logic [N_LP-1:0]              end_condition_lp_o,
    output logic                         end_lp_o,
    output logic                         busy_o,
    output logic                         done_o
);
    localparam int W  = NBIT_LP_IV;
    localparam int DW = (HWLP_RF_SIZE > 2) ? $clog2(HWLP_RF_SIZE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                   r_state, w_next;
    logic [N_LP-1:0][W-1:0]   r_iv, r_init, r_bound, r_stride, w_iv_next, w_stride_in;
    logic [N_LP-1:0]          w_last, w_step, w_init_ge;
    logic [DW-1:0]            r_drain;
    logic                     r_done, w_run, w_valid, w_end, w_drain_end;

    for (genvar k = 0; k < N_LP; k++) begin : g_lp
        localparam logic [N_LP-1:0] LOW = N_LP'((64'd1 << k) - 64'd1);
        // sum in W+1 bits so an overflowing step counts as the last value
        assign w_last[k]      = ({1'b0, r_iv[k]} + {1'b0, r_stride[k]}) >= {1'b0, r_bound[k]};
        assign w_step[k]      = &(w_last | ~LOW);
        assign w_iv_next[k]   = w_step[k] ? (w_last[k] ? r_init[k] : r_iv[k] + r_stride[k]) : r_iv[k];
        assign w_stride_in[k] = (lp_stride_i[k*W +: W] == '0) ? W'(1) : lp_stride_i[k*W +: W];
        assign w_init_ge[k]   = lp_init_i[k*W +: W] >= lp_bound_i[k*W +: W];
    end

    assign w_run       = r_state == RUN;
    assign w_valid     = w_run && !stall_i;
    assign w_end       = w_valid && (&w_last);
    assign w_drain_end = (r_state == DRAIN) && (r_drain == DW'(HWLP_RF_SIZE - 2));

    assign rf_en_o            = r_state != IDLE;
    assign busy_o             = r_state != IDLE;
    assign hwlp_valid_o       = w_valid;
    assign loop_vars_o        = w_run ? r_iv : '0;
    assign end_condition_lp_o = w_valid ? w_last : '0;
    assign end_lp_o           = w_end;
    assign done_o             = r_done;

    always_comb begin
        w_next = r_state;
        if (clear_i)
            w_next = IDLE;
        else if (r_state == IDLE && start_i)
            w_next = (|w_init_ge) ? DRAIN : RUN;
        else if (w_end)
            w_next = DRAIN;
        else if (w_drain_end)
            w_next = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= IDLE;
            r_iv     <= '0;
            r_init   <= '0;
            r_bound  <= '0;
            r_stride <= '0;
            r_drain  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_drain_end && !clear_i;
            r_drain <= (r_state == DRAIN) ? r_drain + 1'b1 : '0;
            if (r_state == IDLE && start_i && !clear_i) begin
                r_init   <= lp_init_i;
                r_bound  <= lp_bound_i;
                r_stride <= w_stride_in;
                r_iv     <= lp_init_i;
            end else if (w_valid && !w_end) begin
                r_iv <= w_iv_next;
            end
        end
    end
endmodule
